eif_scheduler: RTL and testbench
================================

EIF_SCHEDULER -- requirements
Module: eif_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of virtual neurons time-multiplexed onto one EIF update datapath.
REQ-002 Parameter STATE_W, default 8: width of membrane state and input current.
REQ-003 Parameter EVT_DEPTH, default 4: spike-event FIFO depth (power of two).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  write strobe for per-neuron input current.
REQ-007 cfg_addr  in  log2(N_NEURONS)  neuron index for cfg_we.
REQ-008 cfg_current  in  STATE_W  current value written at cfg_addr.
REQ-009 start  in  1  request one timestep update of all neurons.
REQ-010 busy  out  1  high while a timestep is in progress.
REQ-011 done  out  1  one-cycle pulse when a timestep completes.
REQ-012 dp_current  out  STATE_W  current presented to the datapath.
REQ-013 dp_state  out  STATE_W  present membrane state presented to the datapath.
REQ-014 dp_next_state  in  STATE_W  datapath result, valid one cycle after issue.
REQ-015 dp_spike  in  1  datapath spike flag, valid with dp_next_state.
REQ-016 evt_valid  out  1  spike event available.
REQ-017 evt_id  out  log2(N_NEURONS)  index of spiking neuron.
REQ-018 evt_ready  in  1  consumer accepts event when evt_valid and evt_ready are both high.
REQ-019 overflow  out  1  sticky flag; a spike event was dropped.
REQ-020 overflow_clr  in  1  clears overflow.

Function
REQ-021 The block SHALL hold per-neuron registers cur[i] and mem[i], each STATE_W wide.
REQ-022 FSM states: IDLE, ISSUE, CAPTURE, DONE.
REQ-023 IDLE: start=1 -> ISSUE with index k=0 and busy=1 from the next cycle; start while not IDLE SHALL be ignored.
REQ-024 ISSUE: dp_current=cur[k], dp_state=mem[k]; next state CAPTURE.
REQ-025 CAPTURE: mem[k]<=dp_next_state; if dp_spike, push k into the event FIFO; then k==N_NEURONS-1 -> DONE, else k<=k+1 and ISSUE.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, return to IDLE; a timestep takes exactly 2*N_NEURONS+1 cycles from the cycle after start to done.
REQ-027 In IDLE, dp_current and dp_state SHALL be 0.
REQ-028 cfg_we SHALL write cur[cfg_addr] in any state; a write to neuron k during its ISSUE cycle takes effect from the next timestep.
REQ-029 FIFO: evt_valid = not empty; evt_id = head entry; pop on evt_valid&&evt_ready.
REQ-030 A push to a full FIFO with no simultaneous pop SHALL be dropped and overflow set; with a simultaneous pop, the push SHALL succeed.
REQ-031 overflow_clr SHALL clear overflow; if a drop occurs in the same cycle, overflow remains 1.
REQ-032 Event ordering SHALL be ascending neuron index within a timestep, FIFO order across timesteps.

Reset
REQ-033 rst SHALL force IDLE, k=0, all cur[i]=0, all mem[i]=0, FIFO empty, busy=0, done=0, evt_valid=0, overflow=0, dp outputs=0.
REQ-034 rst asserted mid-timestep SHALL abort it with no done pulse; partially updated mem values are cleared.

Structure
REQ-035 Shared package eif_pkg SHALL hold the FSM state typedef and default STATE_W/N_NEURONS constants.
REQ-036 The event FIFO SHALL be a separate sub-module eif_evt_fifo (synchronous, count-based full/empty, pointers wrap modulo EVT_DEPTH).

Verification
REQ-037 cur={10,20,30,40}, datapath model next=state+current, no spike; start -> done 9 cycles later, mem={10,20,30,40}; second start -> mem={20,40,60,80}.
REQ-038 Datapath spikes for neurons 1 and 3, evt_ready=1 -> events id=1 then id=3, evt_valid low afterwards, overflow=0.
REQ-039 All neurons spike for 2 timesteps, evt_ready=0 -> FIFO holds 0,1,2,3, 4 dropped pushes, overflow=1; overflow_clr -> overflow=0.
REQ-040 FIFO full, evt_ready=1 held while neuron 0 spikes -> pop and push in same cycle, no drop, overflow stays 0.
REQ-041 start during busy, and cfg_we to neuron 2 during its ISSUE cycle -> no restart; new current used only in the next timestep.
REQ-042 rst pulse during CAPTURE of neuron 2 -> next cycle busy=0, all mem=0, FIFO empty, no done pulse.

Source files
------------

// File: rtl/eif_pkg.sv
// Shared types and default sizing for the time-multiplexed EIF neuron scheduler.
package eif_pkg;

    localparam int DEF_STATE_W   = 8;
    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_EVT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } eif_state_t;

    // Index width that stays legal even for a single-entry structure.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eif_evt_fifo.sv
// Spike-event FIFO: count-based full/empty, reports pushes rejected while full.
module eif_evt_fifo
    import eif_pkg::*;
#(
    parameter int DEPTH = DEF_EVT_DEPTH,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         drop
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        valid   = (count_q != '0);
        head    = mem_q[rd_ptr_q];
        full    = (count_q == FULL_CNT);
        do_pop  = pop && valid;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/eif_scheduler.sv
// Sequences N virtual EIF neurons through one shared update datapath, two cycles per neuron.
module eif_scheduler
    import eif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int STATE_W   = DEF_STATE_W,
    parameter int EVT_DEPTH = DEF_EVT_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [idx_width(N_NEURONS)-1:0]  cfg_addr,
    input  logic [STATE_W-1:0]               cfg_current,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [STATE_W-1:0]               dp_current,
    output logic [STATE_W-1:0]               dp_state,
    input  logic [STATE_W-1:0]               dp_next_state,
    input  logic                             dp_spike,
    output logic                             evt_valid,
    output logic [idx_width(N_NEURONS)-1:0]  evt_id,
    input  logic                             evt_ready,
    output logic                             overflow,
    input  logic                             overflow_clr
);

    localparam int IDX_W = idx_width(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_NEURONS - 1);

    eif_state_t         state_q;
    eif_state_t         state_d;
    logic [IDX_W-1:0]   k_q;
    logic [STATE_W-1:0] cur_q [N_NEURONS];
    logic [STATE_W-1:0] mem_q [N_NEURONS];
    logic               evt_push;
    logic               evt_drop;
    logic               overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                cur_q[i] <= '0;
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
                cur_q[cfg_addr] <= cfg_current;
            end
            if (state_q == CAPTURE) begin
                mem_q[k_q] <= dp_next_state;
                k_q        <= (k_q == LAST_K) ? '0 : k_q + 1'b1;
            end
        end
    end

    // Datapath operands are only driven during ISSUE; the result returns in CAPTURE.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        dp_current = '0;
        dp_state   = '0;
        evt_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                busy       = 1'b1;
                dp_current = cur_q[k_q];
                dp_state   = mem_q[k_q];
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                busy     = 1'b1;
                evt_push = dp_spike;
                state_d  = (k_q == LAST_K) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    eif_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data (k_q),
        .pop       (evt_ready),
        .valid     (evt_valid),
        .head      (evt_id),
        .drop      (evt_drop)
    );

    // A drop in the same cycle as a clear wins, so no lost event goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (evt_drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_eif_scheduler.sv
// Directed bench for eif_scheduler with a registered add-only datapath model and event log.
module tb_eif_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_current;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] dp_current;
    logic [7:0] dp_state;
    logic [7:0] dp_next_state = '0;
    logic       dp_spike = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       overflow;
    logic       overflow_clr;

    logic       ready_base;
    logic       ready_cap0_en;
    logic [3:0] spike_mask;
    logic       ph = 1'b0;
    int         idx = 0;
    int         pop_log[$];
    int         drop_cnt = 0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    eif_scheduler #(
        .N_NEURONS (4),
        .STATE_W   (8),
        .EVT_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_current   (cfg_current),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .dp_current    (dp_current),
        .dp_state      (dp_state),
        .dp_next_state (dp_next_state),
        .dp_spike      (dp_spike),
        .evt_valid     (evt_valid),
        .evt_id        (evt_id),
        .evt_ready     (evt_ready),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    // ph=1 marks a CAPTURE cycle, so ready can be raised exactly while neuron 0 captures.
    assign evt_ready = ready_base | (ready_cap0_en && busy && ph && (idx == 0));

    always @(posedge clk) begin
        if (rst || !busy) begin
            ph  <= 1'b0;
            idx <= 0;
        end else begin
            if (!ph) begin
                dp_next_state <= dp_state + dp_current;
                dp_spike      <= spike_mask[idx];
            end else begin
                idx <= idx + 1;
            end
            ph <= ~ph;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) pop_log.push_back(int'(evt_id));
            if (dut.u_fifo.drop) drop_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int logAt(input int i);
        return (i < pop_log.size()) ? pop_log[i] : -1;
    endfunction

    task automatic setCurrent(input logic [1:0] a, input logic [7:0] v);
        cfg_we      = 1'b1;
        cfg_addr    = a;
        cfg_current = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Pulses start, then runs a fixed 12-cycle window with optional stray start, cfg write and reset.
    task automatic applyStimulus(input int again_cyc, input int cfg_cyc,
                                 input logic [1:0] ca, input logic [7:0] cv,
                                 input int rst_cyc,
                                 output int done_cyc, output int done_cnt,
                                 output logic busy1, output logic busy_after_rst);
        done_cyc       = -1;
        done_cnt       = 0;
        busy1          = 1'b0;
        busy_after_rst = 1'b1;
        start          = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (n == 1) busy1 = busy;
            if (n == rst_cyc + 1) busy_after_rst = busy;
            start       = (n == again_cyc);
            cfg_we      = (n == cfg_cyc);
            cfg_addr    = ca;
            cfg_current = cv;
            rst         = (n == rst_cyc);
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic checkMem(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_mem%0d", tag, i), int'(dut.mem_q[i]), exp_v[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   dc;
        int   dn;
        logic b1;
        logic bar;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_current = '0; start = 1'b0;
        overflow_clr = 1'b0; ready_base = 1'b0; ready_cap0_en = 1'b0; spike_mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_evt_valid", evt_valid, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_dp_current", dp_current, 0);
        checkOutput("rst_dp_state", dp_state, 0);

        $display("[TB] accumulate timesteps");
        setCurrent(2'd0, 8'd10);
        setCurrent(2'd1, 8'd20);
        setCurrent(2'd2, 8'd30);
        setCurrent(2'd3, 8'd40);
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        checkOutput("ts1_busy_next", b1, 1);
        checkOutput("ts1_done_cycle", dc, 9);
        checkOutput("ts1_done_count", dn, 1);
        checkMem("ts1", 10, 20, 30, 40);
        checkOutput("idle_dp_current", dp_current, 0);
        checkOutput("idle_dp_state", dp_state, 0);
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        checkOutput("ts2_done_cycle", dc, 9);
        checkMem("ts2", 20, 40, 60, 80);

        $display("[TB] spikes on neurons 1 and 3");
        pop_log.delete();
        spike_mask = 4'b1010;
        ready_base = 1'b1;
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        checkOutput("spk_log_size", pop_log.size(), 2);
        checkOutput("spk_first_id", logAt(0), 1);
        checkOutput("spk_second_id", logAt(1), 3);
        checkOutput("spk_evt_valid", evt_valid, 0);
        checkOutput("spk_overflow", overflow, 0);

        $display("[TB] overflow with consumer stalled");
        ready_base = 1'b0;
        spike_mask = 4'b1111;
        drop_cnt   = 0;
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        checkOutput("ovf_done_count", dn, 1);
        checkOutput("ovf_drops", drop_cnt, 4);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_evt_valid", evt_valid, 1);
        checkOutput("ovf_head_id", evt_id, 0);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);

        $display("[TB] push and pop on a full FIFO");
        pop_log.delete();
        drop_cnt      = 0;
        spike_mask    = 4'b0001;
        ready_cap0_en = 1'b1;
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        ready_cap0_en = 1'b0;
        checkOutput("full_drops", drop_cnt, 0);
        checkOutput("full_overflow", overflow, 0);
        ready_base = 1'b1;
        repeat (6) @(negedge clk);
        ready_base = 1'b0;
        checkOutput("full_log_size", pop_log.size(), 5);
        checkOutput("full_log0", logAt(0), 0);
        checkOutput("full_log1", logAt(1), 1);
        checkOutput("full_log2", logAt(2), 2);
        checkOutput("full_log3", logAt(3), 3);
        checkOutput("full_log4", logAt(4), 0);
        checkOutput("full_drained", evt_valid, 0);

        $display("[TB] stray start and late current write");
        doReset();
        checkMem("rst2", 0, 0, 0, 0);
        spike_mask = 4'b0000;
        setCurrent(2'd0, 8'd1);
        setCurrent(2'd1, 8'd2);
        setCurrent(2'd2, 8'd3);
        setCurrent(2'd3, 8'd4);
        applyStimulus(3, 5, 2'd2, 8'd100, 0, dc, dn, b1, bar);
        checkOutput("stray_done_cycle", dc, 9);
        checkOutput("stray_done_count", dn, 1);
        checkOutput("stray_busy_after", busy, 0);
        checkMem("late1", 1, 2, 3, 4);
        applyStimulus(0, 0, 2'd0, 8'd0, 0, dc, dn, b1, bar);
        checkMem("late2", 2, 4, 103, 8);

        $display("[TB] reset during capture of neuron 2");
        spike_mask = 4'b1111;
        applyStimulus(0, 0, 2'd0, 8'd0, 6, dc, dn, b1, bar);
        checkOutput("abort_busy_next", bar, 0);
        checkOutput("abort_done_count", dn, 0);
        checkMem("abort", 0, 0, 0, 0);
        checkOutput("abort_evt_valid", evt_valid, 0);
        checkOutput("abort_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
